myproject_mul_pipe_rnd: RTL and testbench

//  Parametrised pipelined signed multiplier with valid/ready flow control and a rounding right-shift.

---
 rtl/myproject_mul_pipe_rnd.sv | 107 ++++++++++
 tb/tb_myproject_mul_pipe_rnd.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/myproject_mul_pipe_rnd.sv
// rtl/myproject_mul_pipe_rnd.sv - pipelined signed multiplier with round-half-up right shift and valid/ready flow
// Optional MYPROJECT_MUL_SAT_EN: clamp result to dout range and expose sat flag.
module myproject_mul_pipe_rnd #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 15,
    parameter int dout_WIDTH = 28,
    parameter int SHIFT      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout
`ifdef MYPROJECT_MUL_SAT_EN
    ,
    output logic                  sat
`endif
);
    localparam int P   = din0_WIDTH + din1_WIDTH;
    localparam int W   = (P + 1 > dout_WIDTH) ? P + 1 : dout_WIDTH;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [P:0] RND = (SHIFT > 0) ? ({{P{1'b0}}, 1'b1} << RSH) : '0;

    // ID is an instance tag only; the empty block just keeps it referenced.
    if (ID < 0) begin : g_id_tag
    end

    logic signed [P-1:0] prod;
    logic signed [P:0]   pext;
    logic signed [P:0]   r;
    logic signed [W-1:0] rw;
    logic [dout_WIDTH-1:0] s1_dout;
    logic adv;

    assign prod = P'($signed(din0)) * P'($signed(din1));
    assign pext = (P + 1)'(prod);
    assign r    = (pext + RND) >>> SHIFT;
    assign rw   = W'(r);

`ifdef MYPROJECT_MUL_SAT_EN
    localparam logic signed [W-1:0] SMAX = {{(W - dout_WIDTH + 1){1'b0}}, {(dout_WIDTH - 1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = ~SMAX;
    logic s1_sat;

    always_comb begin
        s1_sat  = 1'b0;
        s1_dout = dout_WIDTH'(rw);
        if (rw > SMAX) begin
            s1_sat  = 1'b1;
            s1_dout = dout_WIDTH'(SMAX);
        end else if (rw < SMIN) begin
            s1_sat  = 1'b1;
            s1_dout = dout_WIDTH'(SMIN);
        end
    end
`else
    assign s1_dout = dout_WIDTH'(rw);
`endif

    logic [dout_WIDTH-1:0] st_d [NUM_STAGE];
    logic [NUM_STAGE-1:0]  st_v;
`ifdef MYPROJECT_MUL_SAT_EN
    logic [NUM_STAGE-1:0]  st_s;
`endif

    // Stall is global: every stage moves together, so bubbles are never collapsed.
    assign adv      = ce & (~st_v[NUM_STAGE-1] | out_ready);
    assign in_ready = adv & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_v <= '0;
            for (int k = 0; k < NUM_STAGE; k++) begin
                st_d[k] <= '0;
            end
`ifdef MYPROJECT_MUL_SAT_EN
            st_s <= '0;
`endif
        end else if (adv) begin
            st_v[0] <= in_valid;
            st_d[0] <= s1_dout;
`ifdef MYPROJECT_MUL_SAT_EN
            st_s[0] <= s1_sat;
`endif
            for (int k = 1; k < NUM_STAGE; k++) begin
                st_v[k] <= st_v[k-1];
                st_d[k] <= st_d[k-1];
`ifdef MYPROJECT_MUL_SAT_EN
                st_s[k] <= st_s[k-1];
`endif
            end
        end
    end

    assign out_valid = st_v[NUM_STAGE-1];
    assign dout      = st_d[NUM_STAGE-1];
`ifdef MYPROJECT_MUL_SAT_EN
    assign sat       = st_s[NUM_STAGE-1];
`endif
endmodule

// File: tb/tb_myproject_mul_pipe_rnd.sv
// tb/tb_myproject_mul_pipe_rnd.sv - self-checking bench for myproject_mul_pipe_rnd (default and SHIFT=4 instances)
// Honours MYPROJECT_MUL_SAT_EN when defined.
module tb_myproject_mul_pipe_rnd;
    localparam int NS = 2;

    logic clk = 1'b0;
    logic reset, ce, in_valid, out_ready;
    logic [15:0] din0;
    logic [14:0] din1;
    logic in_ready, out_valid, in_ready4, out_valid4;
    logic [27:0] dout;
    logic [23:0] dout4;
`ifdef MYPROJECT_MUL_SAT_EN
    logic sat, sat4;
`endif

    int errors = 0;
    int checks = 0;
    bit last_acc;

    typedef struct {
        longint e0;
        longint e4;
        bit     s0;
        bit     s4;
        int     age;
    } item_t;
    item_t q[$];

    always #5 clk = ~clk;

    myproject_mul_pipe_rnd dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
`ifdef MYPROJECT_MUL_SAT_EN
        , .sat(sat)
`endif
    );

    myproject_mul_pipe_rnd #(.dout_WIDTH(24), .SHIFT(4)) dut4 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready4),
        .din0(din0), .din1(din1), .out_valid(out_valid4), .out_ready(out_ready), .dout(dout4)
`ifdef MYPROJECT_MUL_SAT_EN
        , .sat(sat4)
`endif
    );

    function automatic longint ref_r(longint a, longint b, int sh);
        longint p = a * b;
        if (sh == 0) return p;
        return (p + (longint'(1) <<< (sh - 1))) >>> sh;
    endfunction

    function automatic longint narrow(longint r, int w, output bit s);
        s = 1'b0;
`ifdef MYPROJECT_MUL_SAT_EN
        begin
            longint hi = (longint'(1) <<< (w - 1)) - 1;
            longint lo = -(longint'(1) <<< (w - 1));
            if (r > hi) begin s = 1'b1; return hi; end
            if (r < lo) begin s = 1'b1; return lo; end
            return r;
        end
`else
        return (r <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // One cycle: drive at negedge, check against the model, then apply the model's edge update.
    task automatic cyc(bit iv, longint a, longint b, bit c, bit ordy);
        bit mv, adv;
        item_t it;
        @(negedge clk);
        in_valid = iv; din0 = 16'(a); din1 = 15'(b); ce = c; out_ready = ordy;
        #1;
        mv  = (q.size() > 0) && (q[0].age == NS);
        adv = c && (!mv || ordy);
        chk("in_ready", 64'(in_ready), 64'(adv));
        chk("in_ready4", 64'(in_ready4), 64'(adv));
        chk("out_valid", 64'(out_valid), 64'(mv));
        chk("out_valid4", 64'(out_valid4), 64'(mv));
        if (mv) begin
            chk("dout", longint'($signed(dout)), q[0].e0);
            chk("dout4", longint'($signed(dout4)), q[0].e4);
`ifdef MYPROJECT_MUL_SAT_EN
            chk("sat", 64'(sat), 64'(q[0].s0));
            chk("sat4", 64'(sat4), 64'(q[0].s4));
`endif
        end
        last_acc = iv && adv;
        if (adv) begin
            if (mv) void'(q.pop_front());
            if (iv) begin
                it.e0  = narrow(ref_r(a, b, 0), 28, it.s0);
                it.e4  = narrow(ref_r(a, b, 4), 24, it.s4);
                it.age = 0;
                q.push_back(it);
            end
            foreach (q[i]) q[i].age++;
        end
    endtask

    task automatic stream6(bit stall_ordy, bit stall_ce);
        logic signed [15:0] ra [6];
        logic signed [14:0] rb [6];
        int k = 0;
        int t = 0;
        for (int i = 0; i < 6; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 15'($urandom);
        end
        while ((k < 6) && (t < 40)) begin
            bit st = (t >= 3) && (t <= 5);
            cyc(1'b1, longint'(ra[k]), longint'(rb[k]),
                !(stall_ce && (t == 3 || t == 4)), !(stall_ordy && st));
            if (last_acc) k++;
            t++;
        end
        chk("stream6_accepted", 64'(k), 64'(6));
        repeat (8) cyc(1'b0, 0, 0, 1'b1, 1'b1);
        chk("stream6_drained", 64'(q.size()), 64'(0));
    endtask

    initial begin
        logic signed [15:0] ra;
        logic signed [14:0] rb;
        reset = 1'b1; ce = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din0 = '0; din1 = '0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic product and latency
        cyc(1'b1, 1234, -567, 1'b1, 1'b1);
        cyc(1'b0, 0, 0, 1'b1, 1'b1);
        chk("t1_not_yet", 64'(out_valid), 64'(0));
        cyc(1'b0, 0, 0, 1'b1, 1'b1);
        chk("t1_valid", 64'(out_valid), 64'(1));
        chk("t1_dout", longint'($signed(dout)), -699678);

        // Overflow: wrap or clamp
        cyc(1'b1, -32768, -16384, 1'b1, 1'b1);
        cyc(1'b0, 0, 0, 1'b1, 1'b1);
        cyc(1'b0, 0, 0, 1'b1, 1'b1);
`ifdef MYPROJECT_MUL_SAT_EN
        chk("t2_dout_sat", longint'($signed(dout)), 134217727);
        chk("t2_sat", 64'(sat), 64'(1));
`else
        chk("t2_dout_wrap", longint'($signed(dout)), 0);
`endif

        // Rounding with SHIFT=4
        cyc(1'b1, 7, 5, 1'b1, 1'b1);
        cyc(1'b1, -7, 5, 1'b1, 1'b1);
        cyc(1'b1, 8, 1, 1'b1, 1'b1);
        chk("t3_round_pos", longint'($signed(dout4)), 2);
        cyc(1'b0, 0, 0, 1'b1, 1'b1);
        chk("t3_round_neg", longint'($signed(dout4)), -2);
        cyc(1'b0, 0, 0, 1'b1, 1'b1);
        chk("t3_round_tie", longint'($signed(dout4)), 1);
        cyc(1'b0, 0, 0, 1'b1, 1'b1);

        stream6(1'b1, 1'b0);
        stream6(1'b0, 1'b1);

        // Reset with two results in flight
        cyc(1'b1, 100, 200, 1'b1, 1'b1);
        cyc(1'b1, -300, 400, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_out_valid", 64'(out_valid), 64'(0));
        chk("t6_dout", 64'(dout), 64'(0));
        chk("t6_in_ready", 64'(in_ready), 64'(0));
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) cyc(1'b0, 0, 0, 1'b1, 1'b1);

        // Random traffic with random ce/out_ready
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 15'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'sh8000;
            if ($urandom_range(0, 7) == 0) rb = 15'sh4000;
            cyc(1'($urandom), longint'(ra), longint'(rb),
                $urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0);
        end
        repeat (10) cyc(1'b0, 0, 0, 1'b1, 1'b1);
        chk("final_drained", 64'(q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
